// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side program counter controller.
// Owns the PC register. Each cycle it chooses between sequential fetch (PC+4),
// a branch/jump redirect, or holding the PC because of an instruction-cache or
// data-memory stall. A boot/run/hold state machine sequences this behaviour.
// A redirect that arrives during a stall is remembered and applied once the
// stall clears.
// Optional feature: define PC_SEQ_STALL_COUNTER_EN to add the STALL_COUNT
// output, a saturating count of stalled cycles in RUN/HOLD.

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INSTR_BUSYWAIT,
    input  logic        DATA_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic        JUMP,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC,
    output logic        INSTR_READ,
    output logic        STALL,
    output logic        FETCH_VALID
`ifdef PC_SEQ_STALL_COUNTER_EN
    ,
    output logic [31:0] STALL_COUNT
`endif
);

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned BOOT_W    = 4;
    localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT    = RESET_VECTOR & ALIGN_MASK;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [BOOT_W-1:0]   boot_cnt;
    logic                pending;
    logic [ADDR_W-1:0]   pending_target;

    logic                busy;
    logic                redir;
    logic [ADDR_W-1:0]   target_aligned;
    logic [ADDR_W-1:0]   pc_next_seq;
    logic [ADDR_W-1:0]   hold_resume;

    // Stall/redirect decode and candidate next addresses.
    always_comb begin
        busy           = INSTR_BUSYWAIT | DATA_BUSYWAIT;
        redir          = BRANCH_TAKEN | JUMP;
        target_aligned = BRANCH_TARGET & ALIGN_MASK;
        pc_next_seq    = PC + PC_STEP;
        hold_resume    = pending ? pending_target : PC;
        if (redir) begin
            hold_resume = target_aligned;
        end
    end

    // Boot/run/hold sequencing with the PC, pending redirect and read request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= ST_BOOT;
            boot_cnt       <= '0;
            pending        <= 1'b0;
            pending_target <= '0;
            PC             <= PC_INIT;
            INSTR_READ     <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    boot_cnt <= boot_cnt + BOOT_W'(1);
                    if (boot_cnt == BOOT_LAST) begin
                        state      <= ST_RUN;
                        INSTR_READ <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!busy) begin
                        PC <= redir ? target_aligned : pc_next_seq;
                    end else if (redir) begin
                        pending_target <= target_aligned;
                        pending        <= 1'b1;
                        state          <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!busy) begin
                        PC      <= hold_resume;
                        pending <= 1'b0;
                        state   <= ST_RUN;
                    end else if (redir) begin
                        // Latest redirect wins while the stall persists.
                        pending_target <= target_aligned;
                    end
                end
                default: begin
                    state      <= ST_BOOT;
                    boot_cnt   <= '0;
                    pending    <= 1'b0;
                    INSTR_READ <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline hold and fetch-delivered flags; both forced low while in reset.
    always_comb begin
        STALL       = RESET & ((state == ST_BOOT) | busy);
        FETCH_VALID = RESET & (state != ST_BOOT) & ~INSTR_BUSYWAIT;
    end

`ifdef PC_SEQ_STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    // Saturating count of stalled posedges once fetching has started.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt <= '0;
        end else if ((state != ST_BOOT) && busy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign STALL_COUNT = stall_cnt;
`endif

endmodule
